// File: rtl/bk_pkg.sv
// ---------------------------------------------------------------------------
// bk_pkg
//   Shared constants and the stage-1 register layout for bk_diff_recover.
//
//   W     : addend width (the sum is W+1 bits).
//   HALF  : width of the low slice handled by stage 1 (W = 2*HALF).
//   s1_t  : everything stage 2 needs from stage 1:
//             d_lo : low-half difference S[HALF-1:0] - A[HALF-1:0]
//             b1   : borrow out of the low half
//             s_hi : S[W:HALF]   (includes the adder carry-out)
//             a_hi : A[W-1:HALF]
// ---------------------------------------------------------------------------
package bk_pkg;

    localparam int W    = 12;
    localparam int HALF = 6;

    typedef struct packed {
        logic [HALF-1:0] d_lo;
        logic            b1;
        logic [HALF:0]   s_hi;
        logic [HALF-1:0] a_hi;
    } s1_t;

endpackage

// File: rtl/bk_sub_slice.sv
// ---------------------------------------------------------------------------
// bk_sub_slice
//   N-bit subtractor diff = a - b - bin with borrow-out, using parallel-prefix
//   borrow generation so the borrow chain depth is log2(N) rather than N.
//
//   a, b  : in  N   operands
//   bin   : in  1   borrow-in
//   diff  : out N   (a - b - bin) mod 2^N
//   bout  : out 1   borrow out of the top bit (1 when a < b + bin)
// ---------------------------------------------------------------------------
module bk_sub_slice #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 1;

    // Bit i generates a borrow when a=0,b=1 and passes an incoming borrow
    // through when a==b.
    logic [N-1:0] gen_b;
    logic [N-1:0] prop_b;
    // grp_g[i] ends up as the borrow out of bits [i:0], including bin.
    logic [N-1:0] grp_g;
    logic [N-1:0] grp_p;
    logic [N-1:0] nxt_g;
    logic [N-1:0] nxt_p;
    logic [N-1:0] bor_in;

    assign gen_b  = ~a & b;
    assign prop_b = ~(a ^ b);

    always_comb begin
        grp_g = gen_b;
        grp_p = prop_b;
        nxt_g = '0;
        nxt_p = '0;
        // Fold the borrow-in into bit 0 so every group result below
        // already accounts for it.
        grp_g[0] = gen_b[0] | (prop_b[0] & bin);
        grp_p[0] = 1'b0;
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            nxt_g = grp_g;
            nxt_p = grp_p;
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= (32'd1 << lvl)) begin
                    nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (32'd1 << lvl)]);
                    nxt_p[i] = grp_p[i] & grp_p[i - (32'd1 << lvl)];
                end
            end
            grp_g = nxt_g;
            grp_p = nxt_p;
        end
    end

    always_comb begin
        bor_in = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i == 0) begin
                bor_in[i] = bin;
            end else begin
                bor_in[i] = grp_g[i-1];
            end
        end
    end

    assign diff = a ^ b ^ bor_in;
    assign bout = grp_g[N-1];

endmodule

// File: rtl/bk_diff_recover.sv
// ---------------------------------------------------------------------------
// bk_diff_recover
//   Two-stage pipelined inverse of a W-bit adder: given sum S (W+1 bits) and
//   addend A (W bits) it recovers B = S - A and flags pairs no W-bit B could
//   have produced. Stage 1 subtracts the low HALF bits, stage 2 the high part
//   with the stage-1 borrow. Valid/ready on both sides, 2-entry buffering.
//
//   clk       : in  1    clock, rising edge
//   rst_n     : in  1    asynchronous active-low reset
//   in_valid  : in  1    in_sum/in_addend valid
//   in_ready  : out 1    pair accepted this cycle
//   in_sum    : in  W+1  sum S (bit W is the adder carry-out)
//   in_addend : in  W    known addend A
//   out_valid : out 1    result valid
//   out_ready : in  1    consumer accepts the result
//   out_diff  : out W    (S - A) mod 2^W
//   out_err   : out 1    S - A < 0 or S - A >= 2^W
// ---------------------------------------------------------------------------
module bk_diff_recover
    import bk_pkg::*;
#(
    parameter int W    = bk_pkg::W,
    parameter int HALF = bk_pkg::HALF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_sum,
    input  logic [W-1:0] in_addend,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_diff,
    output logic         out_err
);

    logic            v1;
    s1_t             s1_q;
    logic            adv1;
    logic            adv2;

    logic [HALF-1:0] d_lo;
    logic            b1;
    logic [HALF:0]   h_lo;
    logic            h_neg;

    // ------------------------------------------------------------------
    // Flow control: a stage advances when the stage after it can take
    // its contents or it holds nothing worth keeping.
    // ------------------------------------------------------------------
    assign adv2     = out_ready | ~out_valid;
    assign adv1     = adv2 | ~v1;
    assign in_ready = adv1;

    // ------------------------------------------------------------------
    // Stage 1: low-half subtract
    // ------------------------------------------------------------------
    bk_sub_slice #(
        .N (HALF)
    ) u_lo (
        .a    (in_sum[HALF-1:0]),
        .b    (in_addend[HALF-1:0]),
        .bin  (1'b0),
        .diff (d_lo),
        .bout (b1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_q <= '{d_lo: d_lo,
                          b1:   b1,
                          s_hi: in_sum[W:HALF],
                          a_hi: in_addend[W-1:HALF]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: high part {0,S_hi} - {00,A_hi} - b1, done as a HALF+1 bit
    // subtract whose borrow-out stands in for the sign bit H[HALF+1].
    // h_lo[HALF] set means the result overflowed W bits.
    // ------------------------------------------------------------------
    bk_sub_slice #(
        .N (HALF + 1)
    ) u_hi (
        .a    (s1_q.s_hi),
        .b    ({1'b0, s1_q.a_hi}),
        .bin  (s1_q.b1),
        .diff (h_lo),
        .bout (h_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                out_diff <= {h_lo[HALF-1:0], s1_q.d_lo};
                out_err  <= h_neg | h_lo[HALF];
            end
        end
    end

endmodule

// File: tb/tb_bk_diff_recover.sv
// ---------------------------------------------------------------------------
// tb_bk_diff_recover
//   Self-checking bench for bk_diff_recover. Inputs are driven and outputs
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bk_diff_recover;
    import bk_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   in_sum;
    logic [W-1:0] in_addend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_err;

    always #5 clk = ~clk;

    bk_diff_recover #(
        .W    (W),
        .HALF (HALF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_addend (in_addend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_err   (out_err)
    );

    typedef struct {
        logic [W:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic         e;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         err;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    int   emitted  = 0;
    res_t sb[$];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole values.
    function automatic res_t model(input logic [W:0] s, input logic [W-1:0] a);
        res_t r;
        int   d;
        d      = int'(s) - int'(a);
        r.diff = d[W-1:0];
        r.err  = (d < 0) || (d >= (1 << W));
        return r;
    endfunction

    // One clock of handshake traffic with scoreboard checking.
    task automatic cycle(input logic v, input logic [W:0] s, input logic [W-1:0] a,
                         input logic rdy, output logic acc);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        in_sum    = s;
        in_addend = a;
        out_ready = rdy;
        #1;
        acc = v & in_ready;
        if (out_valid && rdy) begin
            if (sb.size() == 0) begin
                check1("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check1("sb_diff", {20'd0, out_diff}, {20'd0, e.diff});
                check1("sb_err", {31'd0, out_err}, {31'd0, e.err});
                emitted++;
            end
        end
        if (acc) sb.push_back(model(s, a));
    endtask

    // Offer one pair until it is accepted, bounded.
    task automatic send(input logic [W:0] s, input logic [W-1:0] a, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) cycle(1'b1, s, a, rdy, acc);
        if (!acc) check1("send_timeout", 32'd0, 32'd1);
    endtask

    // Run with out_ready high and no input until everything has emerged.
    task automatic drain();
        logic acc;
        for (int n = 0; n < 20 && (sb.size() != 0 || out_valid); n++)
            cycle(1'b0, '0, '0, 1'b1, acc);
        check1("drain_empty", sb.size(), 32'd0);
        check1("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Single isolated transaction against hand-computed expectations;
    // the pipeline must be empty on entry.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sum    = v.s;
        in_addend = v.a;
        out_ready = 1'b1;
        #1;
        check1({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check1({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check1({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check1({tag, "_diff"}, {20'd0, out_diff}, {20'd0, v.d});
        check1({tag, "_err"}, {31'd0, out_err}, {31'd0, v.e});
        @(negedge clk);
        #1;
        check1({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[12];
        logic         acc;
        logic [W:0]   ss[200];
        logic [W-1:0] aa[200];
        logic [W-1:0] bb[200];
        logic [W:0]   bs[4];
        logic [W-1:0] ba[4];
        logic [W:0]   rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0};
        vecs[1]  = '{13'h0040, 12'h001, 12'h03F, 1'b0};
        vecs[2]  = '{13'h0005, 12'h007, 12'hFFE, 1'b1};
        vecs[3]  = '{13'h1000, 12'h000, 12'h000, 1'b1};
        vecs[4]  = '{13'h0000, 12'h000, 12'h000, 1'b0};
        vecs[5]  = '{13'h0FFF, 12'h000, 12'hFFF, 1'b0};
        vecs[6]  = '{13'h0000, 12'h001, 12'hFFF, 1'b1};
        vecs[7]  = '{13'h1FFF, 12'hFFF, 12'h000, 1'b1};
        vecs[8]  = '{13'h0ABC, 12'h123, 12'h999, 1'b0};
        vecs[9]  = '{13'h1234, 12'h235, 12'hFFF, 1'b0};
        vecs[10] = '{13'h003F, 12'h040, 12'hFFF, 1'b1};
        vecs[11] = '{13'h0800, 12'h7FF, 12'h001, 1'b0};

        // ---------------- reset with traffic offered ----------------
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 13'h1FFE;
        in_addend = 12'hFFF;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check1("rst_out_diff", {20'd0, out_diff}, 32'd0);
            check1("rst_out_err", {31'd0, out_err}, 32'd0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check1("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end

        // ---------------- directed table ----------------
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---------------- streaming, exact latency ----------------
        for (int i = 0; i < 200; i++) begin
            aa[i] = 12'($urandom_range(0, 4095));
            bb[i] = 12'($urandom_range(0, 4095));
            ss[i] = {1'b0, aa[i]} + {1'b0, bb[i]};
        end
        for (int c = 0; c <= 202; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c < 200) begin
                in_valid  = 1'b1;
                in_sum    = ss[c];
                in_addend = aa[c];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 200) check1("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (c >= 2 && c < 202) begin
                check1("stream_valid", {31'd0, out_valid}, 32'd1);
                check1("stream_diff", {20'd0, out_diff}, {20'd0, bb[c-2]});
                check1("stream_err", {31'd0, out_err}, 32'd0);
            end else begin
                check1("stream_idle", {31'd0, out_valid}, 32'd0);
            end
        end

        // ---------------- backpressure ----------------
        bs[0] = 13'h0123; ba[0] = 12'h001;
        bs[1] = 13'h1000; ba[1] = 12'hFFF;
        bs[2] = 13'h0003; ba[2] = 12'h004;
        bs[3] = 13'h0FFF; ba[3] = 12'h0F0;
        // T1 and T2 are accepted into the empty pipe with out_ready low.
        @(negedge clk);
        in_valid = 1'b1; in_sum = bs[0]; in_addend = ba[0]; out_ready = 1'b0;
        #1;
        check1("bp_rdy_t1", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_sum = bs[1]; in_addend = ba[1];
        #1;
        check1("bp_rdy_t2", {31'd0, in_ready}, 32'd1);
        check1("bp_out_empty", {31'd0, out_valid}, 32'd0);
        // Both stages now full: input blocked, output holds T1.
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            in_sum = bs[2]; in_addend = ba[2];
            #1;
            check1("bp_rdy_full", {31'd0, in_ready}, 32'd0);
            check1("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check1("bp_hold_diff", {20'd0, out_diff}, 32'h122);
            check1("bp_hold_err", {31'd0, out_err}, 32'd0);
        end
        sb.push_back(model(bs[0], ba[0]));
        sb.push_back(model(bs[1], ba[1]));
        emitted = 0;
        send(bs[2], ba[2], 1'b1);
        send(bs[3], ba[3], 1'b1);
        drain();
        check1("bp_count", emitted, 32'd4);

        // ---------------- reset mid-stream ----------------
        cycle(1'b1, 13'h0777, 12'h111, 1'b0, acc);
        check1("mid_acc1", {31'd0, acc}, 32'd1);
        cycle(1'b1, 13'h0222, 12'h333, 1'b0, acc);
        check1("mid_acc2", {31'd0, acc}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check1("mid_full", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check1("mid_rst_diff", {20'd0, out_diff}, 32'd0);
        check1("mid_rst_err", {31'd0, out_err}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            check1("mid_no_ghost", {31'd0, out_valid}, 32'd0);
        end
        run_vec(vecs[8], "mid_after");

        // ---------------- randomised handshake ----------------
        emitted = 0;
        for (int n = 0; n < 400; n++) begin
            ra = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) begin
                rb = 12'($urandom_range(0, 4095));
                rs = {1'b0, ra} + {1'b0, rb};
            end else begin
                rs = 13'($urandom_range(0, 8191));
            end
            cycle(1'($urandom_range(0, 1)), rs, ra, 1'($urandom_range(0, 1)), acc);
        end
        drain();
        check1("rand_progress", {31'd0, (emitted > 50)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
